// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Defines the response-owner encoding and the address legality check.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int unsigned DEF_ADDR_W     = 5;
  localparam int unsigned DEF_STARVE_MAX = 4;

  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_D  = 1;

  // Misaligned, or any bit above the memory's word-address range set.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant selection for the fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on conflict; default is data priority with a starvation guard.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
  parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             if_req_i,
  input  logic             d_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic             last_d_i,
`else
  input  logic [CNT_W-1:0] starve_cnt_i,
`endif
  output logic [1:0]       gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      // The port granted most recently yields the conflict.
      if (last_d_i) gnt_o[GNT_IF] = 1'b1;
      else          gnt_o[GNT_D]  = 1'b1;
`else
      if (starve_cnt_i == CNT_W'(STARVE_MAX)) gnt_o[GNT_IF] = 1'b1;
      else                                    gnt_o[GNT_D]  = 1'b1;
`endif
    end else if (if_req_i) begin
      gnt_o[GNT_IF] = 1'b1;
    end else if (d_req_i) begin
      gnt_o[GNT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single-port, 1-cycle-latency memory.
// Optional macro MEM_ARB_RR_EN switches conflict resolution to round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [1:0]  gnt_raw;
  logic        gnt_if, gnt_d, any_gnt, bad;
  logic [31:0] sel_addr;
  owner_e      owner_q, owner_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;
`else
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_prio (
    .if_req_i     (if_req),
    .d_req_i      (d_req),
`ifdef MEM_ARB_RR_EN
    .last_d_i     (last_d_q),
`else
    .starve_cnt_i (cnt_q),
`endif
    .gnt_o        (gnt_raw)
  );

  // Grants are suppressed asynchronously while reset is held.
  assign gnt_if  = gnt_raw[GNT_IF] & ~reset;
  assign gnt_d   = gnt_raw[GNT_D] & ~reset;
  assign any_gnt = gnt_if | gnt_d;
  assign if_gnt  = gnt_if;
  assign d_gnt   = gnt_d;

  assign sel_addr  = gnt_d ? d_addr : if_addr;
  assign bad       = addr_bad(sel_addr, ADDR_W);
  assign mem_en    = any_gnt & ~bad;
  assign mem_we    = gnt_d & d_we & ~bad;
  assign mem_addr  = any_gnt ? sel_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = gnt_d ? d_wdata : '0;

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_d)       owner_d = OWN_D;
    else if (gnt_if) owner_d = OWN_IF;
    err_d = any_gnt & bad;
    wr_d  = gnt_d & d_we;
`ifdef MEM_ARB_RR_EN
    last_d_d = last_d_q;
    if (any_gnt) last_d_d = gnt_d;
`else
    cnt_d = '0;
    if (if_req && !gnt_if) cnt_d = (cnt_q == CNT_W'(STARVE_MAX)) ? cnt_q : cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q <= 1'b1;
`else
      cnt_q    <= '0;
`endif
    end else begin
      owner_q  <= owner_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
`ifdef MEM_ARB_RR_EN
      last_d_q <= last_d_d;
`else
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Responses: stores and rejected accesses return zero data.
  assign if_rvalid = (owner_q == OWN_IF);
  assign if_err    = if_rvalid & err_q;
  assign if_rdata  = (if_rvalid && !err_q) ? mem_rdata : '0;
  assign d_rvalid  = (owner_q == OWN_D);
  assign d_err     = d_rvalid & err_q;
  assign d_rdata   = (d_rvalid && !err_q && !wr_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus starvation and reset sequences.
// Responses are checked against a scoreboard queue filled at grant time.
module tb_mem_arbiter;

  localparam int unsigned AW     = 5;
  localparam int unsigned STARVE = 4;

  logic          clk, reset;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [31:0]   if_addr, if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reloaded with known contents whenever reset is high.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 2) ? 32'hDEADBEEF : (32'hA000_0000 | i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        err;
    int          due;
  } resp_t;
  resp_t sbq[$];

  task automatic push(input logic is_d, input logic [31:0] data, input logic err);
    resp_t r;
    r.is_d = is_d; r.data = data; r.err = err; r.due = cyc + 1;
    sbq.push_back(r);
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (if_rvalid || d_rvalid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("resp_cycle", cyc, e.due);
        chk("resp_port_d", {31'd0, d_rvalid}, {31'd0, e.is_d});
        chk("resp_port_if", {31'd0, if_rvalid}, {31'd0, !e.is_d});
        chk("resp_rdata", e.is_d ? d_rdata : if_rdata, e.data);
        chk("resp_err", {31'd0, e.is_d ? d_err : if_err}, {31'd0, e.err});
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("resp_missing", 32'd0, 32'd1);
    end
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        eig;
    logic        edg;
    logic        emen;
    logic        emwe;
    logic [4:0]  emaddr;
    logic [31:0] erdata;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dwd, input logic eig,
                              input logic edg, input logic emen, input logic emwe,
                              input logic [4:0] emaddr, input logic [31:0] erdata, input logic eerr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.eig = eig; v.edg = edg; v.emen = emen; v.emwe = emwe; v.emaddr = emaddr;
    v.erdata = erdata; v.eerr = eerr;
    return v;
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk); #1;
    drive(v.ir, v.ia, v.dr, v.dw, v.da, v.dwd);
    @(negedge clk);
    chk($sformatf("v%0d_if_gnt", idx), {31'd0, if_gnt}, {31'd0, v.eig});
    chk($sformatf("v%0d_d_gnt", idx), {31'd0, d_gnt}, {31'd0, v.edg});
    chk($sformatf("v%0d_mem_en", idx), {31'd0, mem_en}, {31'd0, v.emen});
    chk($sformatf("v%0d_mem_we", idx), {31'd0, mem_we}, {31'd0, v.emwe});
    if (v.emen) chk($sformatf("v%0d_mem_addr", idx), {27'd0, mem_addr}, {27'd0, v.emaddr});
    if (v.emwe) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.dwd);
    if (v.eig || v.edg) push(v.edg, v.erdata, v.eerr);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {30'd0, if_gnt, d_gnt}, 32'd0);
    chk({tag, "_mem"}, {30'd0, mem_en, mem_we}, 32'd0);
    chk({tag, "_rvalid"}, {28'd0, if_rvalid, d_rvalid, if_err, d_err}, 32'd0);
    chk({tag, "_rdata"}, if_rdata | d_rdata, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        exp_if;
    int          mcnt;
    logic        mlast_d;

    vecs[0]  = mk(1, 32'h8,         0, 0, 0,           0,     1, 0, 1, 0, 5'd2,  32'hDEADBEEF, 0);
    vecs[1]  = mk(0, 0,             1, 1, 32'h4,       32'h55, 0, 1, 1, 1, 5'd1,  32'h0,        0);
    vecs[2]  = mk(1, 32'h4,         0, 0, 0,           0,     1, 0, 1, 0, 5'd1,  32'h55,       0);
    vecs[3]  = mk(0, 0,             1, 0, 32'h7C,      0,     0, 1, 1, 0, 5'd31, 32'hA000001F, 0);
    vecs[4]  = mk(0, 0,             1, 1, 32'h2,       32'h77, 0, 1, 0, 0, 5'd0,  32'h0,        1);
    vecs[5]  = mk(0, 0,             1, 1, 32'h80,      32'h99, 0, 1, 0, 0, 5'd0,  32'h0,        1);
    vecs[6]  = mk(1, 32'h81,        0, 0, 0,           0,     1, 0, 0, 0, 5'd0,  32'h0,        1);
    vecs[7]  = mk(0, 0,             0, 0, 0,           0,     0, 0, 0, 0, 5'd0,  32'h0,        0);
    vecs[8]  = mk(0, 0,             1, 0, 32'h0,       0,     0, 1, 1, 0, 5'd0,  32'hA0000000, 0);
    vecs[9]  = mk(1, 32'h40,        0, 0, 0,           0,     1, 0, 1, 0, 5'd16, 32'hA0000010, 0);
    vecs[10] = mk(0, 0,             1, 0, 32'h8,       0,     0, 1, 1, 0, 5'd2,  32'hDEADBEEF, 0);
    vecs[11] = mk(1, 32'h1000_0000, 0, 0, 0,           0,     1, 0, 0, 0, 5'd0,  32'h0,        1);

    // Reset with both requests active: everything held low.
    reset = 1'b1;
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    chk_reset_outputs("rst0");
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 12; i++) apply(vecs[i], i);
    idle_cycle();
    idle_cycle();

    // Continuous conflict from a fresh reset.
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    mcnt = 0;
    mlast_d = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      drive(1'b1, 32'hC, 1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
`ifdef MEM_ARB_RR_EN
      exp_if = mlast_d;
      mlast_d = !exp_if;
`else
      exp_if = (mcnt == STARVE);
      mcnt = exp_if ? 0 : ((mcnt == STARVE) ? mcnt : mcnt + 1);
`endif
      chk($sformatf("conflict%0d_if_gnt", k), {31'd0, if_gnt}, {31'd0, exp_if});
      chk($sformatf("conflict%0d_d_gnt", k), {31'd0, d_gnt}, {31'd0, !exp_if});
      push(!exp_if, exp_if ? 32'hA0000003 : 32'hA0000004, 1'b0);
    end
    // Lone fetch after the conflict run is granted at once.
    apply(mk(1, 32'hC, 0, 0, 0, 0, 1, 0, 1, 0, 5'd3, 32'hA0000003, 0), 20);
    idle_cycle();
    idle_cycle();

    // Reset one cycle after a grant: that response must never appear.
    @(posedge clk); #1;
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("prereset_if_gnt", {31'd0, if_gnt}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 32'h8, 1'b1, 1'b1, 32'h4, 32'h1);
    @(negedge clk);
    chk_reset_outputs("rst1");
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle_cycle();
    idle_cycle();
    apply(vecs[0], 30);
    idle_cycle();
    idle_cycle();

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning word-address width of the shared memory (32 words).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning consecutive fetch denials before fetch is forced to win.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports if_req input 1, if_addr input 32, if_gnt output 1, if_rvalid output 1, if_rdata output 32, if_err output 1, forming the fetch requester.
REQ-006 SHALL have ports d_req input 1, d_we input 1, d_addr input 32, d_wdata input 32, d_gnt output 1, d_rvalid output 1, d_rdata output 32, d_err output 1, forming the data (load/store) requester.
REQ-007 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output 32, mem_rdata input 32, driving one single-port synchronous memory with 1-cycle read latency.

Function
REQ-008 SHALL grant at most one requester per cycle; gnt is combinational from req and internal state in the same cycle.
REQ-009 Requester SHALL hold req and payload stable until gnt; arbiter SHALL NOT assume this, sampling payload only in the grant cycle.
REQ-010 On grant, mem_en=1, mem_addr=addr[ADDR_W+1:2], mem_we=d_we (0 for fetch), mem_wdata=d_wdata.
REQ-011 rvalid SHALL assert for exactly one cycle, exactly one cycle after the owning gnt; rdata=mem_rdata for reads, 0 for stores.
REQ-012 Stores SHALL produce d_rvalid as a write acknowledge.
REQ-013 Address with addr[1:0]!=0 or any bit above ADDR_W+1 set SHALL be granted without memory access (mem_en=0), then rvalid+err=1, rdata=0, next cycle.
REQ-014 Owner register SHALL take states NONE, IF, D; next owner = granted port, or NONE when no grant.
REQ-015 Back-to-back grants SHALL be allowed every cycle (full throughput, no bubble between owners).
REQ-016 Fixed policy: data wins on conflict; starvation counter increments on each cycle if_req=1 and if_gnt=0, clears on if_gnt or if_req=0, saturates at STARVE_MAX.
REQ-017 When counter==STARVE_MAX and both request, fetch SHALL win that cycle.
REQ-018 Single requester SHALL always be granted immediately regardless of counter.
REQ-019 When neither requests, all gnt=0, mem_en=0, counter cleared.

Reset
REQ-020 Reset SHALL force owner=NONE, counter=0, rvalid/err/rdata outputs=0, mem_en=mem_we=0, and gnt=0 while reset is high.
REQ-021 Reset asserted with a response pending SHALL drop that response; no rvalid after reset release for pre-reset grants.

Configuration
REQ-022 Macro MEM_ARB_RR_EN defined: conflicts resolved round-robin (last-granted port loses next conflict; initial favour to fetch after reset); starvation counter and STARVE_MAX unused.
REQ-023 Macro MEM_ARB_RR_EN undefined: fixed data priority with starvation guard per REQ-016/017.

Structure
REQ-024 Package mem_arb_pkg SHALL hold owner enum (OWN_NONE, OWN_IF, OWN_D) and default ADDR_W/STARVE_MAX constants.
REQ-025 Grant logic SHALL live in one sub-module mem_arb_prio (inputs: reqs, counter or last-grant; outputs: one-hot grant); datapath muxing and owner/response registers stay in mem_arbiter.

Verification
REQ-026 Fetch only, if_addr=0x8, mem word2=0xDEADBEEF -> if_gnt same cycle, mem_addr=2, if_rvalid next cycle with if_rdata=0xDEADBEEF.
REQ-027 Both request continuously, fixed mode, STARVE_MAX=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF...
REQ-028 Same stimulus with MEM_ARB_RR_EN -> grant sequence IF,D,IF,D...
REQ-029 Store d_addr=0x4 d_wdata=0x55 then fetch 0x4 -> d_rvalid with d_rdata=0, then if_rdata=0x55.
REQ-030 d_addr=0x2 and d_addr=0x80 -> mem_en=0, d_rvalid+d_err next cycle, d_rdata=0; memory unchanged.
REQ-031 Reset pulsed one cycle after a grant -> no rvalid follows; all outputs 0 during reset; first post-reset request granted normally.
